// File: rtl/exp_stream_ctrl.sv
// exp_stream_ctrl
//   Host-side initiator for the modular exponentiation core. Collects a word stream into the
//   operand registers x, r, r2, m, e (NWORDS words each, LSW first) followed by a single word
//   carrying the exponent bit-count t. It then fires a one-cycle exp_start, waits for exp_done,
//   and streams the captured result back out LSW first. The number of core cycles spent per run
//   is kept in cyc_count for profiling.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   s_valid/s_ready/s_data input word stream (operands then t)
//   exp_x .. exp_e, exp_t  operand registers presented to the core
//   exp_start              one-cycle start pulse to the core
//   exp_done, exp_result   core completion pulse and result (valid in the done cycle)
//   m_valid/m_ready/m_data output word stream (result), m_last flags the final word
//   busy                   high while a run is in flight (START, WAIT, SEND)
//   cyc_count              saturating core cycle count of the last/current run

module exp_stream_ctrl #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned OP_W   = 1024,
    parameter int unsigned T_W    = 10
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,

    output logic [OP_W-1:0]   exp_x,
    output logic [OP_W-1:0]   exp_r,
    output logic [OP_W-1:0]   exp_r2,
    output logic [OP_W-1:0]   exp_m,
    output logic [OP_W-1:0]   exp_e,
    output logic [T_W-1:0]    exp_t,
    output logic              exp_start,
    input  logic              exp_done,
    input  logic [OP_W-1:0]   exp_result,

    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,

    output logic              busy,
    output logic [31:0]       cyc_count
);

    localparam int unsigned NWORDS = OP_W / WORD_W;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned NOPS   = 5;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
    // Operand index reaching NOPS means the next accepted word is t.
    localparam logic [2:0]       IDX_T     = 3'(NOPS);

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StSend  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [OP_W-1:0]   op_q [NOPS];
    logic              op_we;
    logic [T_W-1:0]    t_q, t_d;
    logic [OP_W-1:0]   result_q, result_d;
    logic [31:0]       cyc_q, cyc_d;
    // Shared word counter: input word within an operand in LOAD, output word index in SEND.
    logic [CNT_W-1:0]  word_q, word_d;
    logic [2:0]        idx_q, idx_d;

    logic              in_hs;
    logic              out_hs;

    assign in_hs  = s_valid & s_ready;
    assign out_hs = m_valid & m_ready;

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        cyc_d    = cyc_q;
        result_d = result_q;
        t_d      = t_q;
        op_we    = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (in_hs) begin
                    if (idx_q == IDX_T) begin
                        t_d     = s_data[T_W-1:0];
                        idx_d   = '0;
                        word_d  = '0;
                        state_d = StStart;
                    end else begin
                        op_we = 1'b1;
                        if (word_q == LAST_WORD) begin
                            word_d = '0;
                            idx_d  = idx_q + 1'b1;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end
                end
            end

            StStart: begin
                cyc_d   = '0;
                state_d = StWait;
            end

            StWait: begin
                // The done cycle itself is counted, so increment unconditionally here.
                if (cyc_q != 32'hFFFF_FFFF) begin
                    cyc_d = cyc_q + 32'd1;
                end
                if (exp_done) begin
                    result_d = exp_result;
                    word_d   = '0;
                    state_d  = StSend;
                end
            end

            StSend: begin
                if (out_hs) begin
                    result_d = result_q >> WORD_W;
                    if (word_q == LAST_WORD) begin
                        word_d  = '0;
                        state_d = StLoad;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StLoad;
            idx_q    <= '0;
            word_q   <= '0;
            cyc_q    <= '0;
            result_q <= '0;
            t_q      <= '0;
            for (int i = 0; i < int'(NOPS); i++) begin
                op_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            cyc_q    <= cyc_d;
            result_q <= result_d;
            t_q      <= t_d;
            if (op_we) begin
                op_q[idx_q][word_q*WORD_W +: WORD_W] <= s_data;
            end
        end
    end

    // Outputs are decoded from registered state only.
    assign s_ready   = (state_q == StLoad);
    assign exp_start = (state_q == StStart);
    assign m_valid   = (state_q == StSend);
    assign m_data    = result_q[WORD_W-1:0];
    assign m_last    = (state_q == StSend) && (word_q == LAST_WORD);
    assign busy      = (state_q != StLoad);
    assign cyc_count = cyc_q;

    assign exp_x  = op_q[0];
    assign exp_r  = op_q[1];
    assign exp_r2 = op_q[2];
    assign exp_m  = op_q[3];
    assign exp_e  = op_q[4];
    assign exp_t  = t_q;

endmodule

// File: tb/tb_exp_stream_ctrl.sv
// Bench for exp_stream_ctrl: directed sequence of loads and runs with randomized data,
// input gaps and output backpressure, checked against a word-array model of the stream.

module tb_exp_stream_ctrl;

    logic          clk = 1'b0;
    logic          resetn;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic [1023:0] exp_x, exp_r, exp_r2, exp_m, exp_e;
    logic [9:0]    exp_t;
    logic          exp_start;
    logic          exp_done;
    logic [1023:0] exp_result;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic          m_last;
    logic          busy;
    logic [31:0]   cyc_count;

    int checks = 0;
    int errors = 0;

    // Model: the 161 input words of the current load and the 32 result words of the current run.
    logic [31:0] ld [161];
    logic [31:0] rw [32];

    exp_stream_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .exp_x      (exp_x),
        .exp_r      (exp_r),
        .exp_r2     (exp_r2),
        .exp_m      (exp_m),
        .exp_e      (exp_e),
        .exp_t      (exp_t),
        .exp_start  (exp_start),
        .exp_done   (exp_done),
        .exp_result (exp_result),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .cyc_count  (cyc_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1023:0] get_op(input int idx);
        case (idx)
            0:       return exp_x;
            1:       return exp_r;
            2:       return exp_r2;
            3:       return exp_m;
            default: return exp_e;
        endcase
    endfunction

    function automatic logic [1023:0] rand_wide();
        logic [1023:0] v;
        for (int k = 0; k < 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Operand word w of operand idx must be input word idx*32+w; t is the low 10 bits of word 160.
    task automatic check_ops(input string pfx);
        logic [1023:0] op;
        for (int idx = 0; idx < 5; idx++) begin
            op = get_op(idx);
            for (int w = 0; w < 32; w++) begin
                chk($sformatf("%s_op%0d_w%0d", pfx, idx, w), 64'(op[w*32 +: 32]), 64'(ld[idx*32+w]));
            end
        end
        chk({pfx, "_t"}, 64'(exp_t), 64'(ld[160] & 32'h3FF));
    endtask

    // Stream ld[] in; gap_pct percent of cycles idle. Returns in the START cycle.
    task automatic load_words(input int gap_pct, input bit stray);
        int  k;
        int  budget;
        bit  gap;
        bit  rdy;
        k = 0;
        budget = 0;
        while (k < 161 && budget < 2000) begin
            gap = ($urandom_range(99) < gap_pct);
            s_valid = !gap;
            s_data  = gap ? $urandom : ld[k];
            if (stray && gap) begin
                exp_done   = 1'b1;
                exp_result = rand_wide();
            end else begin
                exp_done = 1'b0;
            end
            chk("load_busy", 64'(busy), 64'd0);
            chk("load_mvalid", 64'(m_valid), 64'd0);
            chk("load_start", 64'(exp_start), 64'd0);
            rdy = s_ready;
            tick();
            if (s_valid && rdy) k++;
            budget++;
        end
        s_valid  = 1'b0;
        exp_done = 1'b0;
        if (k < 161) chk("load_timeout", 64'(k), 64'd161);
    endtask

    // Entered in the START cycle. Core answers lat cycles after exp_start.
    // mode 0: m_ready always 1; 1: toggles 1,0,1,0; 2: random.
    task automatic run_core(input int lat, input int mode, input bit stray);
        int           k;
        int           budget;
        bit           stalled;
        logic [31:0]  hd;
        logic         hl;
        chk("start_pulse", 64'(exp_start), 64'd1);
        chk("start_sready", 64'(s_ready), 64'd0);
        chk("start_busy", 64'(busy), 64'd1);
        for (int i = 1; i <= lat; i++) begin
            tick();
            chk("wait_start", 64'(exp_start), 64'd0);
            chk("wait_mvalid", 64'(m_valid), 64'd0);
            if (i == lat) begin
                exp_done = 1'b1;
                for (int w = 0; w < 32; w++) exp_result[w*32 +: 32] = rw[w];
            end
        end
        tick();
        exp_done   = 1'b0;
        exp_result = rand_wide();
        chk("send_mvalid_rise", 64'(m_valid), 64'd1);
        chk("cyc_count", 64'(cyc_count), 64'(lat));

        k = 0;
        budget = 0;
        stalled = 1'b0;
        hd = '0;
        hl = 1'b0;
        while (k < 32 && budget < 500) begin
            if (stalled) begin
                chk("hold_data", 64'(m_data), 64'(hd));
                chk("hold_last", 64'(m_last), 64'(hl));
            end
            chk("send_mvalid", 64'(m_valid), 64'd1);
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (budget % 2 == 0);
                default: m_ready = 1'($urandom_range(1));
            endcase
            if (stray && budget == 3) begin
                exp_done   = 1'b1;
                exp_result = rand_wide();
            end
            if (m_ready) begin
                chk($sformatf("data_w%0d", k), 64'(m_data), 64'(rw[k]));
                chk($sformatf("last_w%0d", k), 64'(m_last), 64'(k == 31));
                k++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hd = m_data;
                hl = m_last;
            end
            tick();
            exp_done = 1'b0;
            budget++;
        end
        m_ready = 1'b0;
        if (k < 32) chk("send_timeout", 64'(k), 64'd32);
        chk("end_sready", 64'(s_ready), 64'd1);
        chk("end_mvalid", 64'(m_valid), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_cyc_hold", 64'(cyc_count), 64'(lat));
    endtask

    initial begin
        resetn     = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        exp_done   = 1'b0;
        exp_result = '0;
        m_ready    = 1'b0;

        // T1: reset
        tick();
        tick();
        resetn = 1'b1;
        chk("rst_sready", 64'(s_ready), 64'd1);
        chk("rst_start", 64'(exp_start), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        chk("rst_mlast", 64'(m_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_x_zero", 64'(|exp_x), 64'd0);
        chk("rst_e_zero", 64'(|exp_e), 64'd0);
        chk("rst_t", 64'(exp_t), 64'd0);
        chk("rst_cyc", 64'(cyc_count), 64'd0);

        // T2: word k = k, continuous valid
        for (int k = 0; k < 161; k++) ld[k] = 32'(k);
        load_words(0, 1'b0);
        check_ops("t2");
        chk("t2_x_hi", 64'(exp_x[63:32]), 64'd1);
        chk("t2_e_top", 64'(exp_e[1023:992]), 64'd159);
        chk("t2_t", 64'(exp_t), 64'd160);

        // T3: run, core answers after 50 cycles
        for (int k = 0; k < 32; k++) rw[k] = 32'hA5A5_0000 + 32'(k);
        run_core(50, 0, 1'b0);
        check_ops("t3_stable");

        // T4: random operands, done in the first WAIT cycle, toggling m_ready
        for (int k = 0; k < 161; k++) ld[k] = $urandom;
        load_words(0, 1'b0);
        check_ops("t4");
        for (int k = 0; k < 32; k++) rw[k] = $urandom;
        run_core(1, 1, 1'b0);

        // T5: T2 operands with input gaps and stray done pulses in LOAD and SEND
        for (int k = 0; k < 161; k++) ld[k] = 32'(k);
        load_words(30, 1'b1);
        check_ops("t5");
        for (int k = 0; k < 32; k++) rw[k] = $urandom;
        run_core($urandom_range(2, 40), 2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_done = (i == 1);
            tick();
            chk("t5_no_extra", 64'(m_valid), 64'd0);
        end
        exp_done = 1'b0;

        // T6: reset in the middle of WAIT, late done ignored
        for (int k = 0; k < 161; k++) ld[k] = $urandom;
        load_words(0, 1'b0);
        chk("t6_start", 64'(exp_start), 64'd1);
        for (int i = 1; i <= 50; i++) begin
            tick();
            resetn   = !(i == 10 || i == 11);
            exp_done = (i == 50);
            exp_result = rand_wide();
            if (i >= 13) begin
                chk("t6_mvalid", 64'(m_valid), 64'd0);
                chk("t6_sready", 64'(s_ready), 64'd1);
            end
        end
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_done = 1'b0;
            chk("t6_post_mvalid", 64'(m_valid), 64'd0);
            chk("t6_post_start", 64'(exp_start), 64'd0);
            chk("t6_post_busy", 64'(busy), 64'd0);
        end
        chk("t6_x_zero", 64'(|exp_x), 64'd0);
        chk("t6_t", 64'(exp_t), 64'd0);
        chk("t6_cyc", 64'(cyc_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
